// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - circular reorder buffer with multi-port writeback and in-order commit
// Tag equals slot index; entries retire strictly from head, at most one per cycle.
module rob_multiport #(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = 4,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int RD_W     = 5,
   parameter int WB_PORTS = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         rdy_in,
   input  logic                         alloc_valid,
   output logic                         alloc_ready,
   input  logic [ADDR_W-1:0]            alloc_addr,
   input  logic [RD_W-1:0]              alloc_rd,
   output logic [TAG_W-1:0]             alloc_tag,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_val,
   input  logic                         flush,
   output logic                         commit_valid,
   output logic [TAG_W-1:0]             commit_tag,
   output logic [DATA_W-1:0]            commit_val,
   output logic [ADDR_W-1:0]            commit_addr,
   output logic [RD_W-1:0]              commit_rd,
   output logic [TAG_W:0]               count,
   output logic                         empty
);

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  done;
   logic [RD_W-1:0]   rd_q   [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] val_q  [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [TAG_W:0]    cnt;

   logic              full;
   logic              do_alloc;
   logic              do_commit;
   logic [TAG_W-1:0]  wtag [WB_PORTS];
   logic [DATA_W-1:0] wval [WB_PORTS];
   logic [WB_PORTS-1:0] wb_hit;

   assign full        = (cnt == (TAG_W+1)'(DEPTH));
   assign alloc_ready = ~full;
   assign alloc_tag   = tail;
   assign count       = cnt;
   assign empty       = (cnt == '0);

   // Commit outputs are a pure view of the head slot; flush does not mask commit_valid.
   assign commit_valid = busy[head] & done[head] & rdy_in;
   assign commit_tag   = head;
   assign commit_val   = val_q[head];
   assign commit_addr  = addr_q[head];
   assign commit_rd    = rd_q[head];

   assign do_alloc  = rdy_in & ~flush & alloc_valid & ~full;
   assign do_commit = commit_valid & ~flush;

   // Writeback qualifies against the pre-edge slot state, so a slot being allocated this cycle is not busy yet.
   always_comb begin
      wb_hit = '0;
      for (int k = 0; k < WB_PORTS; k++) begin
         wtag[k]   = wb_tag[k*TAG_W +: TAG_W];
         wval[k]   = wb_val[k*DATA_W +: DATA_W];
         wb_hit[k] = rdy_in & ~flush & wb_valid[k] & busy[wtag[k]] & ~done[wtag[k]];
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy <= '0;
         done <= '0;
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            busy <= '0;
            done <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
         end else begin
            // Descending loop: the last assignment wins, giving the lowest channel priority.
            for (int k = WB_PORTS-1; k >= 0; k--) begin
               if (wb_hit[k]) done[wtag[k]] <= 1'b1;
            end
            if (do_commit) begin
               busy[head] <= 1'b0;
               head       <= head + TAG_W'(1);
            end
            if (do_alloc) begin
               busy[tail] <= 1'b1;
               done[tail] <= 1'b0;
               tail       <= tail + TAG_W'(1);
            end
            case ({do_alloc, do_commit})
               2'b10:   cnt <= cnt + (TAG_W+1)'(1);
               2'b01:   cnt <= cnt - (TAG_W+1)'(1);
               default: cnt <= cnt;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            addr_q[i] <= '0;
            val_q[i]  <= '0;
         end
      end else if (rdy_in && !flush) begin
         for (int k = WB_PORTS-1; k >= 0; k--) begin
            if (wb_hit[k]) val_q[wtag[k]] <= wval[k];
         end
         if (do_alloc) begin
            rd_q[tail]   <= alloc_rd;
            addr_q[tail] <= alloc_addr;
            val_q[tail]  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - directed and randomized bench for rob_multiport
// Random phase compares against an in-order queue model of the buffer.
module tb_rob_multiport;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [31:0] alloc_addr;
   logic [4:0]  alloc_rd;
   logic [3:0]  alloc_tag;
   logic [1:0]  wb_valid;
   logic [7:0]  wb_tag;
   logic [63:0] wb_val;
   logic        flush;
   logic        commit_valid;
   logic [3:0]  commit_tag;
   logic [31:0] commit_val;
   logic [31:0] commit_addr;
   logic [4:0]  commit_rd;
   logic [4:0]  count;
   logic        empty;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] val;
      bit          done;
   } ent_t;
   ent_t q[$];
   int   mtail;

   always #5 clk_in = ~clk_in;

   rob_multiport dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
      .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .flush(flush),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_val(commit_val),
      .commit_addr(commit_addr), .commit_rd(commit_rd), .count(count), .empty(empty)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rdy_in = 1'b1; alloc_valid = 1'b0; alloc_addr = '0; alloc_rd = '0;
      wb_valid = '0; wb_tag = '0; wb_val = '0; flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wb0(input int tag, input logic [31:0] v);
      wb_valid = 2'b01; wb_tag[3:0] = tag[3:0]; wb_val[31:0] = v;
   endtask

   task automatic alloc_n(input int n, input int base_tag, input logic [31:0] base_addr);
      for (int i = 0; i < n; i++) begin
         alloc_valid = 1'b1; alloc_addr = base_addr + 32'(4*i); alloc_rd = 5'(i + 1);
         #1;
         chk("alloc_tag_seq", alloc_tag, 64'((base_tag + i) % 16));
         tick();
      end
      alloc_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      bit exp_cv, pre_ready;
      int t;

      // reset state
      idle();
      rst_n_in = 1'b0;
      repeat (2) tick();
      #1;
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_val", commit_val, 0);
      chk("rst_commit_addr", commit_addr, 0);
      chk("rst_commit_rd", commit_rd, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      rst_n_in = 1'b1;
      tick();

      // three allocations, out-of-order writeback, in-order retire
      alloc_n(3, 0, 32'h100);
      #1;
      chk("a3_count", count, 3);
      chk("a3_commit_valid", commit_valid, 0);
      wb0(2, 32'hAA);
      tick();
      wb0(0, 32'h11);
      #1;
      chk("wb2_no_commit", commit_valid, 0);
      tick();
      idle();
      #1;
      chk("c0_valid", commit_valid, 1);
      chk("c0_tag", commit_tag, 0);
      chk("c0_val", commit_val, 32'h11);
      chk("c0_addr", commit_addr, 32'h100);
      chk("c0_rd", commit_rd, 1);
      tick();
      #1;
      chk("t1_blocks", commit_valid, 0);
      chk("t1_count", count, 2);
      wb_valid = 2'b10; wb_tag[7:4] = 4'd1; wb_val[63:32] = 32'h22;
      tick();
      idle();
      #1;
      chk("c1_valid", commit_valid, 1);
      chk("c1_tag", commit_tag, 1);
      chk("c1_val", commit_val, 32'h22);
      tick();
      #1;
      chk("c2_valid", commit_valid, 1);
      chk("c2_tag", commit_tag, 2);
      chk("c2_val", commit_val, 32'hAA);
      chk("c2_rd", commit_rd, 3);
      tick();
      #1;
      chk("drain_empty", empty, 1);
      chk("drain_count", count, 0);

      // fill to DEPTH, extra alloc ignored, retire head, wrap to tag 0
      flush = 1'b1;
      tick();
      idle();
      alloc_n(16, 0, 32'h2000);
      #1;
      chk("full_ready", alloc_ready, 0);
      chk("full_count", count, 16);
      alloc_valid = 1'b1; alloc_addr = 32'hDEAD;
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("full_ign_count", count, 16);
      chk("full_ign_tag", alloc_tag, 0);
      wb0(0, 32'h55);
      tick();
      idle();
      alloc_valid = 1'b1; alloc_addr = 32'h3000; alloc_rd = 5'd9;
      #1;
      chk("full_commit_valid", commit_valid, 1);
      chk("full_no_credit", alloc_ready, 0);
      tick();
      #1;
      chk("after_retire_count", count, 15);
      chk("wrap_tag", alloc_tag, 0);
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("wrap_count", count, 16);

      // dual-channel writeback to the same tag: lowest channel wins, later write ignored
      flush = 1'b1;
      tick();
      idle();
      alloc_n(6, 0, 32'h400);
      wb_valid = 2'b11; wb_tag = {4'd5, 4'd5}; wb_val = {32'h2, 32'h1};
      tick();
      wb0(5, 32'h3);
      tick();
      for (int i = 4; i >= 0; i--) begin
         wb0(i, 32'h70 + 32'(i));
         tick();
      end
      idle();
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("dual_seq_valid", commit_valid, 1);
         chk("dual_seq_tag", commit_tag, 64'(i));
         chk("dual_seq_val", commit_val, (i == 5) ? 64'h1 : 64'(32'h70 + 32'(i)));
         tick();
      end

      // flush with six busy entries and a concurrent allocate
      alloc_n(6, 6, 32'h500);
      #1;
      chk("pre_flush_count", count, 6);
      flush = 1'b1; alloc_valid = 1'b1;
      tick();
      idle();
      #1;
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_tag", alloc_tag, 0);

      // rdy_in low freezes everything
      alloc_n(2, 0, 32'h600);
      wb0(0, 32'h99);
      tick();
      idle();
      rdy_in = 1'b0; alloc_valid = 1'b1; wb0(1, 32'h77);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("frz_commit_valid", commit_valid, 0);
         tick();
      end
      idle();
      #1;
      chk("frz_count", count, 2);
      chk("frz_tag", alloc_tag, 2);
      chk("frz_head_valid", commit_valid, 1);
      chk("frz_head_val", commit_val, 32'h99);
      tick();
      #1;
      chk("frz_wb_ignored", commit_valid, 0);

      // asynchronous reset mid-run
      alloc_n(3, 2, 32'h700);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_empty", empty, 1);
      tick();
      rst_n_in = 1'b1;
      tick();

      // randomized phase against the queue model
      q.delete();
      mtail = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rdy_in      = ($urandom_range(0, 9) != 0);
         flush       = ($urandom_range(0, 59) == 0);
         alloc_valid = ($urandom_range(0, 9) < 6);
         alloc_addr  = $urandom;
         alloc_rd    = 5'($urandom_range(0, 31));
         for (int k = 0; k < 2; k++) begin
            wb_valid[k] = ($urandom_range(0, 2) != 0);
            if (q.size() > 0 && $urandom_range(0, 4) != 0) t = q[$urandom_range(0, q.size() - 1)].tag;
            else t = $urandom_range(0, 15);
            wb_tag[k*4 +: 4]   = t[3:0];
            wb_val[k*32 +: 32] = $urandom;
         end
         #1;
         exp_cv    = rdy_in && q.size() > 0 && q[0].done;
         pre_ready = (q.size() < 16);
         chk("rnd_count", count, 64'(q.size()));
         chk("rnd_empty", empty, 64'(q.size() == 0));
         chk("rnd_alloc_ready", alloc_ready, 64'(pre_ready));
         chk("rnd_alloc_tag", alloc_tag, 64'(mtail));
         chk("rnd_commit_valid", commit_valid, 64'(exp_cv));
         if (exp_cv) begin
            chk("rnd_commit_tag", commit_tag, 64'(q[0].tag));
            chk("rnd_commit_val", commit_val, q[0].val);
            chk("rnd_commit_addr", commit_addr, q[0].addr);
            chk("rnd_commit_rd", commit_rd, q[0].rd);
         end
         if (rdy_in) begin
            if (flush) begin
               q.delete();
               mtail = 0;
            end else begin
               for (int k = 0; k < 2; k++) begin
                  if (wb_valid[k]) begin
                     v = wb_val[k*32 +: 32];
                     foreach (q[j]) begin
                        if (q[j].tag == int'(wb_tag[k*4 +: 4]) && !q[j].done) begin
                           q[j].val  = v;
                           q[j].done = 1'b1;
                        end
                     end
                  end
               end
               if (exp_cv) void'(q.pop_front());
               if (alloc_valid && pre_ready) begin
                  q.push_back('{tag: mtail, rd: alloc_rd, addr: alloc_addr, val: 32'h0, done: 1'b0});
                  mtail = (mtail + 1) % 16;
               end
            end
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
